// File: rtl/pwm_generator_if.sv
// PWM channel bus: the duty level goes in, the PWM waveform and the period marker come out.
// The master side drives duty; the slave side is the generator.
interface pwm_generator_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] duty;
    logic             pwm_out;
    logic             period_start;

    modport master (output duty, input pwm_out, input period_start);
    modport slave  (input duty, output pwm_out, output period_start);
endinterface

// File: rtl/pwm_generator.sv
// Single-channel PWM generator with a double-buffered duty level and a clock-enable prescaler.
// Optional macro PWM_PHASE_CORRECT_EN selects up/down (phase-correct) counting instead of fast mode.
module pwm_generator #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic            clk,
    input  logic            reset,
    pwm_generator_if.slave  bus
);
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [PRE_W-1:0] pre_cnt, pre_cnt_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;
    logic             tick;
    logic             wrap;

`ifdef PWM_PHASE_CORRECT_EN
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
    dir_t dir, dir_nxt;
`endif

    // Next-state logic: prescaler, counter, wrap detection and duty capture.
    always_comb begin
        tick        = (pre_cnt == PRE_W'(PRESCALE - 1));
        pre_cnt_nxt = tick ? '0 : pre_cnt + PRE_W'(1);
        cnt_nxt     = cnt;
        wrap        = 1'b0;
`ifdef PWM_PHASE_CORRECT_EN
        dir_nxt     = dir;
        if (tick) begin
            if (dir == DIR_UP) begin
                cnt_nxt = cnt + WIDTH'(1);
                if (cnt_nxt == MAX) dir_nxt = DIR_DOWN;
            end else begin
                cnt_nxt = cnt - WIDTH'(1);
                if (cnt_nxt == '0) begin
                    dir_nxt = DIR_UP;
                    wrap    = 1'b1;
                end
            end
        end
`else
        if (tick) begin
            cnt_nxt = cnt + WIDTH'(1);
            wrap    = (cnt == MAX);
        end
`endif
        shadow_nxt = wrap ? bus.duty : shadow;
    end

    // State and output registers; compare uses the current count, so the output lags it by one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt          <= '0;
            cnt              <= '0;
            shadow           <= '0;
            bus.pwm_out      <= 1'b0;
            bus.period_start <= 1'b0;
`ifdef PWM_PHASE_CORRECT_EN
            dir              <= DIR_UP;
`endif
        end else begin
            pre_cnt          <= pre_cnt_nxt;
            cnt              <= cnt_nxt;
            shadow           <= shadow_nxt;
            bus.pwm_out      <= (cnt < shadow);
            bus.period_start <= wrap;
`ifdef PWM_PHASE_CORRECT_EN
            dir              <= dir_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: reset, duty levels, extremes, mid-period changes,
// mid-period reset and a prescaled instance; covers both counting modes.
module tb_pwm_generator;
    localparam int unsigned WIDTH = 8;
`ifdef PWM_PHASE_CORRECT_EN
    localparam int PER   = 510;
    localparam bit PHASE = 1'b1;
`else
    localparam int PER   = 256;
    localparam bit PHASE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pwm_generator_if #(.WIDTH(WIDTH)) b1 ();
    pwm_generator_if #(.WIDTH(WIDTH)) b4 ();

    pwm_generator #(.WIDTH(WIDTH), .PRESCALE(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    pwm_generator #(.WIDTH(WIDTH), .PRESCALE(4)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));

    int checks = 0;
    int errors = 0;
    int highs, pulses, last_pos, k;

    // High clks per period for a given shadow level and prescale.
    function automatic int exp_high(input int s, input int pre);
        if (PHASE) return (s == 0) ? 0 : (2 * s - 1) * pre;
        return s * pre;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic pwm_of(input int sel);
        return (sel == 1) ? b1.pwm_out : b4.pwm_out;
    endfunction

    function automatic logic ps_of(input int sel);
        return (sel == 1) ? b1.period_start : b4.period_start;
    endfunction

    // Sample n clks after the current one; record high count, pulse count, last pulse position.
    task automatic win(input int sel, input int n);
        highs = 0; pulses = 0; last_pos = -1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (pwm_of(sel) === 1'b1) highs++;
            if (ps_of(sel) === 1'b1) begin
                pulses++;
                last_pos = i;
            end
        end
    endtask

    // Wait for the next period_start within limit clks; k = clks taken, -1 on timeout.
    task automatic wait_ps(input int sel, input int limit);
        highs = 0; k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (pwm_of(sel) === 1'b1) highs++;
            if (ps_of(sel) === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        b1.duty = 8'd128;
        b4.duty = 8'd3;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_pwm", b1.pwm_out, 0);
            check("rst_ps", b1.period_start, 0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_pwm", b1.pwm_out, 0);
        check("post_rst_ps", b1.period_start, 0);
        wait_ps(1, 4 * PER);
        check("first_ps_latency", k + 1, PER);
        check("first_period_low", highs, 0);

        b1.duty = 8'd64;
        win(1, PER);
        check("duty128_high", highs, exp_high(128, 1));
        check("duty128_pulses", pulses, 1);
        check("duty128_spacing", last_pos, PER);
        win(1, PER);
        check("duty64_high_a", highs, exp_high(64, 1));
        check("duty64_spacing", last_pos, PER);
        win(1, PER);
        check("duty64_high_b", highs, exp_high(64, 1));
        check("duty64_pulses", pulses, 1);

        b1.duty = 8'd0;
        win(1, PER);
        check("duty0_pending", highs, exp_high(64, 1));
        repeat (3) begin
            win(1, PER);
            check("duty0_high", highs, 0);
            check("duty0_pulses", pulses, 1);
        end

        b1.duty = 8'd255;
        win(1, PER);
        check("duty255_pending", highs, 0);
        win(1, PER);
        check("duty255_high", highs, exp_high(255, 1));
        check("duty255_low", PER - highs, PHASE ? 1 : 1);

        // Mid-period change: period with shadow=64, duty moves to 200 at cnt=10.
        b1.duty = 8'd64;
        win(1, PER);
        check("duty255_again", highs, exp_high(255, 1));
        win(1, 10);
        check("mid_first10", highs, 10);
        b1.duty = 8'd200;
        win(1, PER - 10);
        check("mid_rest", highs, exp_high(64, 1) - 10);
        check("mid_pulse_pos", last_pos, PER - 10);
        win(1, PER);
        check("mid_next_high", highs, exp_high(200, 1));

        // Reset mid-period at cnt=100 with the output high.
        win(1, 100);
        check("pre_reset_pwm", b1.pwm_out, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_pwm", b1.pwm_out, 0);
        check("midrst_ps", b1.period_start, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_release_pwm", b1.pwm_out, 0);
        wait_ps(1, 4 * PER);
        check("midrst_ps_latency", k + 1, PER);
        check("midrst_shadow0", highs, 0);
        win(1, PER);
        check("midrst_next_high", highs, exp_high(200, 1));

        // Prescaled instance.
        wait_ps(4, 12 * PER);
        check("pre4_ps_seen", (k > 0) ? 1 : 0, 1);
        win(4, 4 * PER);
        check("pre4_high", highs, exp_high(3, 4));
        check("pre4_pulses", pulses, 1);
        check("pre4_spacing", last_pos, 4 * PER);
        @(posedge clk); #1;
        check("pre4_ps_width", b4.period_start, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
